// File: rtl/mem_arbiter_pkg.sv
// Shared type definitions for the memory arbiter slice.
// rv32i_types carries the machine word; arbiter_types carries the FSM and
// grant encodings used by mem_arbiter.

package rv32i_types;

  typedef logic [31:0] rv32i_word;

endpackage : rv32i_types

package arbiter_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } arb_grant_t;

endpackage : arbiter_types

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single word-wide memory port between instruction
// fetch and load/store. Ties are broken round-robin. The winning request is
// latched at grant time, memory is driven only from those registers, and the
// winner receives a registered one-cycle response pulse.

module mem_arbiter
  import rv32i_types::*;
  import arbiter_types::*;
(
  input  logic       clk,
  input  logic       rst,

  input  logic       i_read,
  input  rv32i_word  i_address,
  output rv32i_word  i_rdata,
  output logic       i_resp,

  input  logic       d_read,
  input  logic       d_write,
  input  logic [3:0] d_byte_enable,
  input  rv32i_word  d_address,
  input  rv32i_word  d_wdata,
  output rv32i_word  d_rdata,
  output logic       d_resp,

  output logic       mem_read,
  output logic       mem_write,
  output logic [3:0] mem_byte_enable,
  output rv32i_word  mem_address,
  output rv32i_word  mem_wdata,
  input  rv32i_word  mem_rdata,
  input  logic       mem_resp
);

  arb_state_t state;
  arb_grant_t last_grant;
  arb_grant_t pick;
  logic       i_req;
  logic       d_req;
  logic       grant_fire;
  logic       serving;
  logic       mem_done;

  // Grant decision: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    i_req      = i_read;
    d_req      = d_read | d_write;
    grant_fire = (state == IDLE) && (i_req || d_req);
    serving    = (state == SERVE_I) || (state == SERVE_D);
    mem_done   = serving && mem_resp;
    pick       = GRANT_I;
    if (d_req && (!i_req || (last_grant == GRANT_I))) begin
      pick = GRANT_D;
    end
  end

  // Arbitration FSM and round-robin history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_D;
    end else begin
      case (state)
        IDLE: begin
          if (grant_fire) begin
            state      <= (pick == GRANT_I) ? SERVE_I : SERVE_D;
            last_grant <= pick;
          end
        end
        SERVE_I,
        SERVE_D: begin
          if (mem_resp) begin
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory-side request registers: loaded on grant, strobe cleared on mem_resp.
  // d_read together with d_write is taken as a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_byte_enable <= '0;
      mem_address     <= '0;
      mem_wdata       <= '0;
    end else if (grant_fire) begin
      if (pick == GRANT_I) begin
        mem_read        <= 1'b1;
        mem_write       <= 1'b0;
        mem_byte_enable <= 4'hF;
        mem_address     <= i_address;
        mem_wdata       <= '0;
      end else begin
        mem_read        <= ~d_write;
        mem_write       <= d_write;
        mem_byte_enable <= d_byte_enable;
        mem_address     <= d_address;
        mem_wdata       <= d_wdata;
      end
    end else if (mem_done) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end
  end

  // Response path: capture read data and pulse the winner's resp for one cycle.
  // Write completions leave d_rdata untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_resp  <= 1'b0;
      d_resp  <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      i_resp <= mem_done && (state == SERVE_I);
      d_resp <= mem_done && (state == SERVE_D);
      if (mem_done && (state == SERVE_I)) begin
        i_rdata <= mem_rdata;
      end
      if (mem_done && (state == SERVE_D) && !mem_write) begin
        d_rdata <= mem_rdata;
      end
    end
  end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic, all cross-checked every cycle
// against a transaction-timeline model of the arbiter.

module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_read;
  logic [31:0] i_address;
  logic [31:0] i_rdata;
  logic        i_resp;
  logic        d_read;
  logic        d_write;
  logic [3:0]  d_byte_enable;
  logic [31:0] d_address;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_resp;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  mem_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .i_read          (i_read),
    .i_address       (i_address),
    .i_rdata         (i_rdata),
    .i_resp          (i_resp),
    .d_read          (d_read),
    .d_write         (d_write),
    .d_byte_enable   (d_byte_enable),
    .d_address       (d_address),
    .d_wdata         (d_wdata),
    .d_rdata         (d_rdata),
    .d_resp          (d_resp),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- transaction-timeline model ----------------
  // A granted transaction has a grant cycle g; the strobe is up from g+1
  // through the cycle mem_resp is seen (r); resp appears at r+1; the arbiter
  // accepts a new request from r+2 on.
  bit          model_ok = 0;
  bit          tx_valid;
  bit          tx_is_d;
  bit          tx_write;
  int          tx_grant;
  int          tx_done;
  int          free_at;
  bit          last_d;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  bit          m_wdata_known;
  logic [31:0] mi_rdata;
  logic [31:0] md_rdata;

  always @(negedge clk) begin
    bit strobe_on;
    bit resp_now;
    bit use_d;
    strobe_on = tx_valid && (cyc > tx_grant) && ((tx_done < 0) || (cyc <= tx_done));
    resp_now  = tx_valid && (tx_done >= 0) && (cyc == tx_done + 1);
    if (model_ok) begin
      check("mdl_mem_read",  {31'd0, mem_read},  {31'd0, strobe_on && !tx_write});
      check("mdl_mem_write", {31'd0, mem_write}, {31'd0, strobe_on && tx_write});
      check("mdl_i_resp",    {31'd0, i_resp},    {31'd0, resp_now && !tx_is_d});
      check("mdl_d_resp",    {31'd0, d_resp},    {31'd0, resp_now && tx_is_d});
      check("mdl_mem_address", mem_address, m_addr);
      check("mdl_mem_be", {28'd0, mem_byte_enable}, {28'd0, m_be});
      if (m_wdata_known) check("mdl_mem_wdata", mem_wdata, m_wdata);
      check("mdl_i_rdata", i_rdata, mi_rdata);
      check("mdl_d_rdata", d_rdata, md_rdata);
    end
    if (rst) begin
      model_ok      = 1;
      tx_valid      = 0;
      tx_is_d       = 0;
      tx_write      = 0;
      tx_grant      = 0;
      tx_done       = -1;
      last_d        = 1;
      free_at       = cyc + 1;
      m_addr        = '0;
      m_wdata       = '0;
      m_be          = '0;
      m_wdata_known = 1;
      mi_rdata      = '0;
      md_rdata      = '0;
    end else if (model_ok) begin
      if ((cyc >= free_at) && (i_read || d_read || d_write)) begin
        use_d         = (d_read || d_write) && (!i_read || !last_d);
        last_d        = use_d;
        tx_valid      = 1;
        tx_is_d       = use_d;
        tx_write      = use_d && d_write;
        tx_grant      = cyc;
        tx_done       = -1;
        free_at       = 1 << 30;
        m_addr        = use_d ? d_address : i_address;
        m_be          = use_d ? d_byte_enable : 4'hF;
        m_wdata       = d_wdata;
        m_wdata_known = use_d;
      end else if (strobe_on && mem_resp) begin
        tx_done = cyc;
        free_at = cyc + 2;
        if (!tx_is_d) mi_rdata = mem_rdata;
        else if (!tx_write) md_rdata = mem_rdata;
      end
    end
  end

  // ---------------- stimulus ----------------
  int          got[6];
  int          n_got;
  int          exp_seq[6] = '{0, 1, 0, 1, 0, 1};

  initial begin
    rst = 1'b1; i_read = 0; i_address = '0; d_read = 0; d_write = 0;
    d_byte_enable = '0; d_address = '0; d_wdata = '0; mem_rdata = '0; mem_resp = 0;
    repeat (3) step();

    // reset state
    check("rst_mem_read",  {31'd0, mem_read}, 0);
    check("rst_mem_write", {31'd0, mem_write}, 0);
    check("rst_mem_addr",  mem_address, 0);
    check("rst_mem_be",    {28'd0, mem_byte_enable}, 0);
    check("rst_i_rdata",   i_rdata, 0);
    check("rst_d_rdata",   d_rdata, 0);
    check("rst_resps",     {30'd0, i_resp, d_resp}, 0);
    rst = 1'b0;
    step();

    // fetch only, memory answers at cycle 3
    i_read = 1; i_address = 32'h60;
    step();
    for (int c = 1; c <= 3; c++) begin
      check("t1_mem_read", {31'd0, mem_read}, 1);
      check("t1_mem_addr", mem_address, 32'h60);
      check("t1_mem_be",   {28'd0, mem_byte_enable}, 32'hF);
      check("t1_i_resp_early", {31'd0, i_resp}, 0);
      if (c == 3) begin mem_resp = 1; mem_rdata = 32'hDEADBEEF; end
      step();
    end
    mem_resp = 0; mem_rdata = '0;
    check("t1_i_resp",    {31'd0, i_resp}, 1);
    check("t1_i_rdata",   i_rdata, 32'hDEADBEEF);
    check("t1_d_resp",    {31'd0, d_resp}, 0);
    check("t1_strobe_off", {31'd0, mem_read}, 0);
    i_read = 0;
    step();
    check("t1_i_resp_pulse", {31'd0, i_resp}, 0);

    // tie right after reset: fetch first, then the write
    rst = 1; step(); rst = 0; step();
    i_read = 1; i_address = 32'h80;
    d_write = 1; d_address = 32'h100; d_wdata = 32'h12345678; d_byte_enable = 4'h3;
    step();
    check("t2_fetch_first", {30'd0, mem_read, mem_write}, 32'h2);
    check("t2_fetch_addr", mem_address, 32'h80);
    mem_resp = 1; mem_rdata = 32'h11111111;
    step();
    mem_resp = 0;
    check("t2_i_resp", {30'd0, i_resp, d_resp}, 32'h2);
    i_read = 0;
    step();
    step();
    check("t2_write_strobe", {30'd0, mem_read, mem_write}, 32'h1);
    check("t2_write_addr", mem_address, 32'h100);
    check("t2_write_be", {28'd0, mem_byte_enable}, 32'h3);
    check("t2_write_data", mem_wdata, 32'h12345678);
    mem_resp = 1;
    step();
    mem_resp = 0;
    check("t2_d_resp", {30'd0, i_resp, d_resp}, 32'h1);
    d_write = 0;
    step();

    // both requesters holding continuously: grants alternate
    step();
    i_read = 1; i_address = 32'h1000; d_write = 1; d_address = 32'h2000;
    n_got = 0;
    for (int c = 0; c < 80 && n_got < 6; c++) begin
      if (i_resp) begin got[n_got] = 0; n_got++; end
      else if (d_resp) begin got[n_got] = 1; n_got++; end
      if (n_got == 6) begin i_read = 0; d_write = 0; end
      mem_resp = mem_read | mem_write;
      mem_rdata = $urandom;
      step();
    end
    i_read = 0; d_write = 0; mem_resp = 0;
    check("t3_grant_count", n_got, 6);
    for (int j = 0; j < 6; j++) if (j < n_got) check("t3_rr_order", got[j], exp_seq[j]);
    step();

    // data request arrives while fetch is being served
    i_read = 1; i_address = 32'h1C0;
    step();
    d_read = 1; d_address = 32'h200; d_byte_enable = 4'hC;
    for (int c = 0; c < 3; c++) begin
      check("t4_hold_read", {31'd0, mem_read}, 1);
      check("t4_hold_addr", mem_address, 32'h1C0);
      check("t4_hold_be",   {28'd0, mem_byte_enable}, 32'hF);
      step();
    end
    mem_resp = 1; mem_rdata = 32'hA5A5A5A5;
    step();
    mem_resp = 0;
    check("t4_i_resp", {31'd0, i_resp}, 1);
    i_read = 0;
    step();
    step();
    check("t4_d_strobe", {31'd0, mem_read}, 1);
    check("t4_d_addr", mem_address, 32'h200);
    check("t4_d_be", {28'd0, mem_byte_enable}, 32'hC);
    mem_resp = 1; mem_rdata = 32'h0BADF00D;
    step();
    mem_resp = 0;
    check("t4_d_resp", {31'd0, d_resp}, 1);
    check("t4_d_rdata", d_rdata, 32'h0BADF00D);
    d_read = 0;
    step();

    // d_read dropped mid-transaction still completes
    d_read = 1; d_address = 32'h300;
    step();
    check("t5_strobe", {31'd0, mem_read}, 1);
    d_read = 0;
    step();
    check("t5_strobe_held", {31'd0, mem_read}, 1);
    check("t5_addr_held", mem_address, 32'h300);
    step();
    mem_resp = 1; mem_rdata = 32'h13579BDF;
    step();
    mem_resp = 0;
    check("t5_d_resp", {31'd0, d_resp}, 1);
    check("t5_d_rdata", d_rdata, 32'h13579BDF);
    step();
    check("t5_d_resp_pulse", {31'd0, d_resp}, 0);

    // reset while serving a write abandons it
    d_write = 1; d_address = 32'h400; d_wdata = 32'hCAFEF00D; d_byte_enable = 4'h5;
    step();
    check("t6_write_strobe", {31'd0, mem_write}, 1);
    rst = 1;
    step();
    check("t6_mem_write", {31'd0, mem_write}, 0);
    check("t6_mem_read",  {31'd0, mem_read}, 0);
    check("t6_mem_addr",  mem_address, 0);
    check("t6_mem_wdata", mem_wdata, 0);
    check("t6_mem_be",    {28'd0, mem_byte_enable}, 0);
    check("t6_rdata",     i_rdata | d_rdata, 0);
    check("t6_resps",     {30'd0, i_resp, d_resp}, 0);
    rst = 0; d_write = 0;
    for (int c = 0; c < 4; c++) begin
      mem_resp = (c == 1);
      step();
      check("t6_no_d_resp", {31'd0, d_resp}, 0);
    end
    mem_resp = 0;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (i_read) begin
        if (i_resp || ($urandom_range(0, 31) == 0)) i_read = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        i_read = 1; i_address = {$urandom} & 32'hFFFF_FFFC;
      end
      if (d_read || d_write) begin
        if (d_resp || ($urandom_range(0, 31) == 0)) begin d_read = 0; d_write = 0; end
      end else if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 7))
          0:       begin d_read = 1; d_write = 1; end
          1, 2, 3: begin d_read = 0; d_write = 1; end
          default: begin d_read = 1; d_write = 0; end
        endcase
        d_address = {$urandom} & 32'hFFFF_FFFC;
        d_wdata = $urandom;
        d_byte_enable = 4'($urandom);
      end
      if (mem_read || mem_write) mem_resp = ($urandom_range(0, 2) == 0);
      else mem_resp = ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
      step();
    end

    rst = 0; i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mem_arbiter
